uart_rx_ctrl: RTL and testbench

16x-oversampling UART receive controller that sequences the baud tick resource: it consumes the synchronous `uart_tick_16x` pulse from the baud generator and drives a start/data/stop state machine over the serial input line. It delivers 8N1 bytes to the bus side through a valid/acknowledge holding register and reports framing and overrun errors. It sits between the baud generator and the UART bus register block.

---
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bus-side handshake of the UART receive controller: received byte, valid/ack
// holding-register handshake and the sticky error flags.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic       read_ack;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_error,
    output overrun,
    output busy,
    input  read_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  overrun,
    input  busy,
    output read_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 16x-oversampling 8N1 UART receiver: start/data/stop FSM advanced only on
// baud ticks, with a valid/ack holding register and sticky error flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           uart_tick_16x,
  input  logic           rx,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam int         ALIGN_SHIFT = 8 - DATA_BITS;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_tick_cnt;
  logic [3:0] w_tick_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_nxt;
  logic [7:0] r_shreg;
  logic       r_sync1;
  logic       r_sync2;
  logic       w_rx_s;

  logic       w_shift;
  logic       w_load;
  logic       w_ferr_set;
  logic       w_busy_nxt;

  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_frame_error;
  logic       r_overrun;
  logic       r_busy;

  assign w_rx_s = r_sync2;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register together with its tick and bit counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_nxt;
    end
  end

  // Next-state logic; every transition is gated by the 16x tick
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        if (uart_tick_16x && !w_rx_s) begin
          w_state_nxt = S_START;
          w_tick_nxt  = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (uart_tick_16x) begin
          if (r_tick_cnt == 4'd7) begin
            // Mid-bit check: a high line here was only a glitch
            if (!w_rx_s) begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = 4'd0;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (uart_tick_16x) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_bit_nxt = r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_BIT) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_DATA;
            end
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (uart_tick_16x) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            if (w_rx_s) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line returns high so a break cannot retrigger
        if (uart_tick_16x && w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = 4'd0;
        w_bit_nxt   = 3'd0;
      end
    endcase
  end

  // Output decode: datapath strobes derived from the current state and tick
  always_comb begin
    w_shift    = 1'b0;
    w_load     = 1'b0;
    w_ferr_set = 1'b0;
    if (uart_tick_16x && (r_tick_cnt == 4'd15)) begin
      w_shift    = (r_state == S_DATA);
      w_load     = (r_state == S_STOP) && w_rx_s;
      w_ferr_set = (r_state == S_STOP) && !w_rx_s;
    end else begin
      w_shift    = 1'b0;
      w_load     = 1'b0;
      w_ferr_set = 1'b0;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Shift register, holding register and sticky flags; a set beats read_ack
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shreg       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shreg <= {w_rx_s, r_shreg[7:1]};
      end
      if (w_load) begin
        r_rx_data <= r_shreg >> ALIGN_SHIFT;
      end
      if (w_load) begin
        r_rx_valid <= 1'b1;
      end else if (bus.read_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frame_error <= 1'b1;
      end else if (bus.read_ack) begin
        r_frame_error <= 1'b0;
      end
      if (w_load && r_rx_valid && !bus.read_ack) begin
        r_overrun <= 1'b1;
      end else if (bus.read_ack) begin
        r_overrun <= 1'b0;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames against a transaction-level
// model of the holding register and flags, with fixed and irregular tick spacing.
module tb_uart_rx_ctrl;
  localparam int NB = 8;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic tick     = 1'b0;
  logic rx       = 1'b1;
  logic read_ack = 1'b0;

  bit rand_gap = 1'b0;
  int gap      = 0;

  int n_checks = 0;
  int n_fails  = 0;

  int tick_count      = 0;
  int valid_rise_tick = 0;
  int busy_hi_count   = 0;
  int nontick_changes = 0;
  bit edge_tick  = 1'b0;
  bit edge_ack   = 1'b0;
  bit edge_rst   = 1'b1;
  bit prev_valid = 1'b0;
  bit prev_busy  = 1'b0;

  bit         exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  bit         exp_ferr  = 1'b0;
  bit         exp_ovr   = 1'b0;

  uart_rx_ctrl_if bus_if ();
  assign bus_if.read_ack = read_ack;

  uart_rx_ctrl #(.DATA_BITS(NB)) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .uart_tick_16x(tick),
    .rx           (rx),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Tick source: every 4 clocks, or irregular 1-7 clock gaps
  initial begin
    forever begin
      @(negedge clk);
      if (gap == 0) begin
        tick = 1'b1;
        gap  = rand_gap ? int'($urandom_range(7, 1)) - 1 : 3;
      end else begin
        tick = 1'b0;
        gap  = gap - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (tick) tick_count <= tick_count + 1;
    edge_tick <= tick;
    edge_ack  <= read_ack;
    edge_rst  <= !reset_n;
  end

  // Observers: rx_valid rise time, busy activity, changes on non-tick edges
  always @(negedge clk) begin
    prev_valid <= bus_if.rx_valid;
    prev_busy  <= bus_if.busy;
    if (bus_if.rx_valid && !prev_valid) valid_rise_tick <= tick_count;
    if (bus_if.busy) busy_hi_count <= busy_hi_count + 1;
    if (!edge_tick && !edge_rst &&
        ((bus_if.busy != prev_busy) || ((bus_if.rx_valid != prev_valid) && !edge_ack)))
      nontick_changes <= nontick_changes + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    exp_valid = 1'b0; exp_data = 8'h00; exp_ferr = 1'b0; exp_ovr = 1'b0;
  endfunction

  function automatic void model_good(input logic [7:0] d, input bit ack_same);
    if (exp_valid && !ack_same) exp_ovr = 1'b1;
    if (ack_same) begin
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
    end
    exp_valid = 1'b1;
    exp_data  = d;
  endfunction

  function automatic void model_ack();
    exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
  endfunction

  task automatic check_all(input string tag);
    @(negedge clk);
    chk_eq({tag, "_valid"}, 32'(bus_if.rx_valid), 32'(exp_valid));
    chk_eq({tag, "_data"},  32'(bus_if.rx_data),  32'(exp_data));
    chk_eq({tag, "_ferr"},  32'(bus_if.frame_error), 32'(exp_ferr));
    chk_eq({tag, "_ovr"},   32'(bus_if.overrun),  32'(exp_ovr));
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic ack_on_next_tick();
    do begin
      @(negedge clk);
      #1;
    end while (!tick);
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    #1;
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
    model_ack();
  endtask

  task automatic reset_dut();
    #1;
    reset_n  = 1'b0;
    rx       = 1'b1;
    read_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    check_all("reset");
    chk_eq("reset_busy", 32'(bus_if.busy), 32'd0);
  endtask

  // One 8N1 frame at 16 ticks/bit; tick 0 is the edge where the start bit begins
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit ack_at_load,
                            input int extra_low, input int abort_bit, output int t0);
    wait_ticks(1);
    rx = 1'b0;
    t0 = tick_count;
    wait_ticks(16);
    for (int i = 0; i < NB; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        reset_n = 1'b0;
        rx      = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        return;
      end
      wait_ticks(16);
    end
    rx = stop_ok;
    if (ack_at_load) begin
      wait_ticks(8);
      ack_on_next_tick();
      wait_ticks(7);
    end else begin
      wait_ticks(16);
    end
    if (!stop_ok && extra_low > 0) begin
      wait_ticks(extra_low);
      chk_eq("wait_high_busy", 32'(bus_if.busy), 32'd1);
      chk_eq("wait_high_valid", 32'(bus_if.rx_valid), 32'(exp_valid));
    end
    rx = 1'b1;
    wait_ticks(4);
    if (stop_ok) model_good(d, ack_at_load);
    else exp_ferr = 1'b1;
  endtask

  initial begin
    int t0;
    int b0;
    logic [7:0] rd;
    bit sok;

    // 1: single byte and its exact arrival time
    reset_dut();
    send_frame(8'hA5, 1'b1, 1'b0, 0, -1, t0);
    check_all("t1_a5");
    chk_eq("t1_latency_ticks", 32'(valid_rise_tick - t0), 32'd153);
    pulse_ack();
    check_all("t1_ack");

    // 2: start glitch, then a clean frame
    b0 = busy_hi_count;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    chk_eq("t2_busy_pulse", 32'(busy_hi_count > b0), 32'd1);
    chk_eq("t2_busy_idle", 32'(bus_if.busy), 32'd0);
    check_all("t2_glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 0, -1, t0);
    check_all("t2_3c");
    pulse_ack();

    // 3: framing error, break held low, following byte, ack with no byte
    reset_dut();
    send_frame(8'h55, 1'b0, 1'b0, 40, -1, t0);
    check_all("t3_ferr");
    send_frame(8'h81, 1'b1, 1'b0, 0, -1, t0);
    check_all("t3_81");
    pulse_ack();
    check_all("t3_ack");
    send_frame(8'h5A, 1'b0, 1'b0, 0, -1, t0);
    check_all("t3_ferr2");
    pulse_ack();
    check_all("t3_ack_novalid");

    // 4: overrun, then the same with read_ack on the load edge
    reset_dut();
    send_frame(8'h11, 1'b1, 1'b0, 0, -1, t0);
    send_frame(8'h22, 1'b1, 1'b0, 0, -1, t0);
    check_all("t4_ovr");
    pulse_ack();
    check_all("t4_ack");
    send_frame(8'h11, 1'b1, 1'b0, 0, -1, t0);
    send_frame(8'h22, 1'b1, 1'b1, 0, -1, t0);
    check_all("t4_ack_at_load");

    // 5: reset during data bit 3
    pulse_ack();
    send_frame(8'hF0, 1'b1, 1'b0, 0, 3, t0);
    check_all("t5_reset");
    chk_eq("t5_busy", 32'(bus_if.busy), 32'd0);
    wait_ticks(200);
    check_all("t5_quiet");
    send_frame(8'h0F, 1'b1, 1'b0, 0, -1, t0);
    check_all("t5_0f");
    pulse_ack();

    // 6: irregular tick spacing, fixed patterns then random bytes
    rand_gap = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0, 0, -1, t0);
    check_all("t6_00");
    pulse_ack();
    send_frame(8'hFF, 1'b1, 1'b0, 0, -1, t0);
    check_all("t6_ff");
    pulse_ack();
    for (int i = 0; i < 8; i++) begin
      rd  = 8'($urandom_range(255, 0));
      sok = ($urandom_range(3, 0) != 0);
      send_frame(rd, sok, 1'b0, 0, -1, t0);
      check_all($sformatf("t6_rand%0d", i));
      if ($urandom_range(1, 0) == 1) pulse_ack();
    end
    chk_eq("nontick_hold", 32'(nontick_changes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
